// File: rtl/crc32_rx_check.sv
// Receive-side CRC-32 checker: bit-serial, MSB-first polynomial division of a
// byte-framed stream including its trailing CRC, with pass/fail and length report.
module crc32_rx_check #(
  parameter logic [31:0] POLYNOMIAL      = 32'h04C11DB7,
  parameter int unsigned MIN_FRAME_BYTES = 5
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [7:0]  i_data,
  input  logic        i_valid,
  input  logic        i_last,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_crc_ok,
  output logic        o_len_err,
  output logic [15:0] o_byte_count,
  output logic [31:0] o_remainder
);

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned CRC_W   = 32;
  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_FRAME_BYTES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ACCEPT = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } state_t;

  state_t           state;
  logic [7:0]       shreg;
  logic             last_q;
  logic [2:0]       bit_cnt;
  logic [CRC_W-1:0] lfsr;
  logic [CNT_W-1:0] count;

  logic [CRC_W-1:0] lfsr_step_c;
  logic             len_err_c;

  // One division step with the next message bit taken from the shift register MSB
  assign lfsr_step_c = {lfsr[CRC_W-2:0], shreg[7]} ^ (lfsr[CRC_W-1] ? POLYNOMIAL : '0);
  assign len_err_c   = (count < MIN_LEN);
  assign o_remainder = lfsr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= ACCEPT;
      shreg        <= '0;
      last_q       <= 1'b0;
      bit_cnt      <= '0;
      lfsr         <= '0;
      count        <= '0;
      o_ready      <= 1'b1;
      o_done       <= 1'b0;
      o_crc_ok     <= 1'b0;
      o_len_err    <= 1'b0;
      o_byte_count <= '0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ACCEPT: begin
          if (i_valid && o_ready) begin
            shreg   <= i_data;
            last_q  <= i_last;
            bit_cnt <= 3'd7;
            if (count != CNT_MAX) begin
              count <= count + 16'd1;
            end
            state   <= SHIFT;
            o_ready <= 1'b0;
          end
        end
        SHIFT: begin
          lfsr    <= lfsr_step_c;
          shreg   <= {shreg[6:0], 1'b0};
          bit_cnt <= bit_cnt - 3'd1;
          if (bit_cnt == 3'd0) begin
            if (last_q) begin
              // Result flags use the remainder being written on this same edge
              state        <= REPORT;
              o_done       <= 1'b1;
              o_len_err    <= len_err_c;
              o_crc_ok     <= (lfsr_step_c == '0) && !len_err_c;
              o_byte_count <= count;
            end else begin
              state   <= ACCEPT;
              o_ready <= 1'b1;
            end
          end
        end
        REPORT: begin
          lfsr    <= '0;
          count   <= '0;
          state   <= ACCEPT;
          o_ready <= 1'b1;
        end
        default: begin
          state   <= ACCEPT;
          o_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_crc32_rx_check.sv
// Directed self-checking bench for crc32_rx_check with hand-computed frames.
module tb_crc32_rx_check;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [7:0]  i_data = '0;
  logic        i_valid = 1'b0;
  logic        i_last = 1'b0;
  logic        o_ready;
  logic        o_done;
  logic        o_crc_ok;
  logic        o_len_err;
  logic [15:0] o_byte_count;
  logic [31:0] o_remainder;

  crc32_rx_check dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_data       (i_data),
    .i_valid      (i_valid),
    .i_last       (i_last),
    .o_ready      (o_ready),
    .o_done       (o_done),
    .o_crc_ok     (o_crc_ok),
    .o_len_err    (o_len_err),
    .o_byte_count (o_byte_count),
    .o_remainder  (o_remainder)
  );

  always #5 i_clk = ~i_clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int acc_cnt = 0;

  logic        q_ok [$];
  logic        q_len [$];
  logic [15:0] q_cnt [$];
  logic [31:0] q_rem [$];
  int          q_dcyc [$];
  int          q_acyc [$];
  logic [7:0]  fr [$];

  // Record every handshake edge index
  always @(posedge i_clk) begin
    cyc <= cyc + 1;
    if (i_rst_n && i_valid && o_ready) begin
      acc_cnt <= acc_cnt + 1;
      q_acyc.push_back(cyc);
    end
  end

  // Capture every reported result
  always @(negedge i_clk) begin
    if (o_done) begin
      done_cnt <= done_cnt + 1;
      q_ok.push_back(o_crc_ok);
      q_len.push_back(o_len_err);
      q_cnt.push_back(o_byte_count);
      q_rem.push_back(o_remainder);
      q_dcyc.push_back(cyc);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte is accepted
  task automatic send_byte(input logic [7:0] d, input logic l, input int gap);
    int tries;
    if (gap > 0) begin
      i_valid = 1'b0;
      repeat (gap) @(negedge i_clk);
    end
    i_valid = 1'b1;
    i_data  = d;
    i_last  = l;
    tries   = 0;
    while (!o_ready && tries < 40) begin
      @(negedge i_clk);
      tries++;
    end
    if (!o_ready) check_eq("accept_timeout", 32'(o_ready), 32'd1);
    @(negedge i_clk);
  endtask

  task automatic send_frame(input int gap_max, input bit hold);
    for (int i = 0; i < fr.size(); i++) begin
      send_byte(fr[i], (i == fr.size() - 1), (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
    end
    if (!hold) i_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int tries;
    tries = 0;
    while (done_cnt < target && tries < 200) begin
      @(negedge i_clk);
      tries++;
    end
    if (done_cnt < target) check_eq("done_timeout", 32'(done_cnt), 32'(target));
  endtask

  task automatic check_result(input string tag, input logic ok, input logic len,
                              input logic [15:0] cnt, input logic [31:0] rem);
    if (q_ok.size() == 0) begin
      check_eq({tag, "_present"}, 32'd0, 32'd1);
    end else begin
      check_eq({tag, "_crc_ok"}, 32'(q_ok.pop_front()), 32'(ok));
      check_eq({tag, "_len_err"}, 32'(q_len.pop_front()), 32'(len));
      check_eq({tag, "_count"}, 32'(q_cnt.pop_front()), 32'(cnt));
      check_eq({tag, "_rem"}, q_rem.pop_front(), rem);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ready"}, 32'(o_ready), 32'd1);
    check_eq({tag, "_done"}, 32'(o_done), 32'd0);
    check_eq({tag, "_crc_ok"}, 32'(o_crc_ok), 32'd0);
    check_eq({tag, "_len_err"}, 32'(o_len_err), 32'd0);
    check_eq({tag, "_count"}, 32'(o_byte_count), 32'd0);
    check_eq({tag, "_rem"}, o_remainder, 32'd0);
  endtask

  initial begin
    int d0;
    int a0;
    repeat (3) @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Good frame: M = 0x01, R = P
    send_byte(8'h01, 1'b0, 0);
    repeat (8) @(negedge i_clk);
    check_eq("rem_after_b1", o_remainder, 32'h0000_0001);
    send_byte(8'h04, 1'b0, 0);
    send_byte(8'hC1, 1'b0, 0);
    send_byte(8'h1D, 1'b0, 0);
    send_byte(8'hB7, 1'b1, 0);
    i_valid = 1'b0;
    wait_done(1);
    check_result("good", 1'b1, 1'b0, 16'd5, 32'h0);
    repeat (5) @(negedge i_clk);
    check_eq("done_once", 32'(done_cnt), 32'd1);
    check_eq("ok_held", 32'(o_crc_ok), 32'd1);
    check_eq("count_held", 32'(o_byte_count), 32'd5);

    // Corrupted last CRC bit
    fr = '{8'h01, 8'h04, 8'hC1, 8'h1D, 8'hB6};
    send_frame(0, 1'b0);
    wait_done(2);
    check_result("bad", 1'b0, 1'b0, 16'd5, 32'h0000_0001);

    // Short frame: remainder is simply the four bytes
    fr = '{8'h01, 8'h02, 8'h03, 8'h04};
    send_frame(0, 1'b0);
    wait_done(3);
    check_result("short", 1'b0, 1'b1, 16'd4, 32'h0102_0304);

    // One-byte frame: zero remainder but illegal length
    fr = '{8'h00};
    send_frame(0, 1'b0);
    wait_done(4);
    check_result("one_byte", 1'b0, 1'b1, 16'd1, 32'h0);

    // Back-to-back frames with i_valid held high
    repeat (2) @(negedge i_clk);
    q_acyc.delete();
    q_dcyc.delete();
    fr = '{8'h02, 8'h09, 8'h82, 8'h3B, 8'h6E};
    send_frame(0, 1'b1);
    fr = '{8'h00, 8'h01, 8'h04, 8'hC1, 8'h1D, 8'hB7};
    send_frame(0, 1'b0);
    wait_done(6);
    check_result("b2b_first", 1'b1, 1'b0, 16'd5, 32'h0);
    check_result("b2b_second", 1'b1, 1'b0, 16'd6, 32'h0);
    check_eq("b2b_accepts", 32'(q_acyc.size()), 32'd11);
    if (q_acyc.size() == 11) begin
      for (int i = 1; i < 11; i++) begin
        check_eq($sformatf("b2b_spacing_%0d", i), 32'(q_acyc[i] - q_acyc[i-1]),
                 (i == 5) ? 32'd10 : 32'd9);
      end
    end
    if (q_dcyc.size() > 0 && q_acyc.size() > 4) begin
      check_eq("b2b_latency", 32'(q_dcyc[0] - q_acyc[4]), 32'd9);
    end else begin
      check_eq("b2b_latency_present", 32'd0, 32'd1);
    end

    // Random idle gaps between bytes
    a0 = acc_cnt;
    fr = '{8'h02, 8'h09, 8'h82, 8'h3B, 8'h6E};
    send_frame(20, 1'b0);
    wait_done(7);
    check_result("gaps_good", 1'b1, 1'b0, 16'd5, 32'h0);
    check_eq("gaps_accepts", 32'(acc_cnt - a0), 32'd5);
    a0 = acc_cnt;
    fr = '{8'h01, 8'h04, 8'hC1, 8'h1D, 8'hB6};
    send_frame(20, 1'b0);
    wait_done(8);
    check_result("gaps_bad", 1'b0, 1'b0, 16'd5, 32'h0000_0001);
    check_eq("gaps_bad_accepts", 32'(acc_cnt - a0), 32'd5);

    // Reset while byte 3 is shifting
    d0 = done_cnt;
    send_byte(8'h01, 1'b0, 0);
    send_byte(8'h04, 1'b0, 0);
    send_byte(8'hC1, 1'b0, 0);
    i_valid = 1'b0;
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (20) @(negedge i_clk);
    check_eq("no_done_after_reset", 32'(done_cnt), 32'(d0));
    fr = '{8'h01, 8'h04, 8'hC1, 8'h1D, 8'hB7};
    send_frame(0, 1'b0);
    wait_done(d0 + 1);
    check_result("post_reset", 1'b1, 1'b0, 16'd5, 32'h0);
    repeat (3) @(negedge i_clk);
    check_eq("leftover_results", 32'(q_ok.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
